reg_alu_ctrl: RTL and testbench
===============================

REG_ALU_CTRL -- requirements
Module: reg_alu_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, which sets the width of the retired-instruction counter.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: reset is asynchronous and active-low.
REQ-004 Port in_valid, input, 1: an instruction is offered.
REQ-005 Port in_ready, output, 1: the controller can accept an instruction.
REQ-006 Port instr, input, 16: the instruction word.
REQ-007 Port sel, output, 1: register-file write-source select (0 = immediate d_in, 1 = ALU result).
REQ-008 Port wr, output, 1: register-file write enable.
REQ-009 Port op, output, 2: ALU operation code.
REQ-010 Port rd_addr_a, output, 3: register-file read port A address.
REQ-011 Port rd_addr_b, output, 3: register-file read port B address.
REQ-012 Port wr_addr, output, 3: register-file write address.
REQ-013 Port d_in, output, 8: immediate data for the register file.
REQ-014 Port cout_in, input, 1: registered ALU carry returned by the datapath.
REQ-015 Port carry, output, 1: carry flag from the last ALU instruction.
REQ-016 Port done, output, 1: one-cycle pulse when an instruction retires.

Function
REQ-017 Instruction format SHALL be: [15] kind (0 = LOAD, 1 = ALU); [12:10] destination register.
REQ-018 ALU instructions SHALL use fields [14:13] op, [9:7] source A and [6:4] source B.
REQ-019 LOAD instructions SHALL use field [7:0] as the immediate.
REQ-020 Unused instruction bits SHALL be ignored.
REQ-021 The FSM SHALL have exactly four states: IDLE, EXEC, WRITE, FLAG.
REQ-022 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-023 The handshake fires when in_valid and in_ready are both 1 at a clock edge; on that edge instr SHALL be latched into an internal register and the FSM SHALL go IDLE -> EXEC.
REQ-024 The transitions EXEC -> WRITE, WRITE -> FLAG and FLAG -> IDLE SHALL each be unconditional and take one cycle.
REQ-025 sel, op, rd_addr_a, rd_addr_b, wr_addr and d_in SHALL be decoded from the latched instruction register and held stable from EXEC through FLAG.
REQ-026 For LOAD, sel SHALL be 0 and d_in SHALL equal the immediate; for ALU, sel SHALL be 1 and d_in SHALL be 0.
REQ-027 wr SHALL be 1 only in WRITE: exactly one cycle, two cycles after the accepting edge.
REQ-028 In FLAG, done SHALL be 1; for an ALU instruction, the edge leaving FLAG SHALL load carry from cout_in.
REQ-029 A LOAD instruction SHALL leave carry unchanged.
REQ-030 Latency from the accepting edge to the done pulse SHALL be 3 cycles; throughput SHALL be one instruction per 4 cycles.
REQ-031 in_valid asserted outside IDLE SHALL be ignored; the instruction stays pending until the next IDLE cycle.
REQ-032 instr changing while the controller is not in IDLE SHALL have no effect.
REQ-033 A source address equal to the destination SHALL be legal, since the write occurs only at the end of WRITE.

Reset
REQ-034 Asserting reset SHALL immediately force: state IDLE, in_ready 1, wr 0, done 0, carry 0, latched instruction 0 (so all address, op, sel and d_in outputs are 0), and the retired counter 0.
REQ-035 Reset asserted during EXEC, WRITE or FLAG SHALL abort the instruction with no done pulse and no further wr.

Configuration
REQ-036 Macro REG_ALU_CTRL_PERF_EN defined: an output port retired [CNT_W-1:0] SHALL exist and SHALL increment by one on each done pulse, wrapping from all-ones to 0.
REQ-037 Macro REG_ALU_CTRL_PERF_EN undefined: the retired port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-038 A shared package SHALL hold the state encoding (2 bits), the instruction field bit positions, and the constants KIND_LOAD = 0 and KIND_ALU = 1.
REQ-039 The block SHALL contain one sub-module, reg_alu_ctrl_decode: combinational, mapping the latched instruction to sel, op, addresses and d_in.
REQ-040 The top level SHALL integrate with reg_alu by a direct port-by-port connection.

Verification
REQ-041 Reset release, then LOAD r3 with 0xA5 (instr 0x0CA5) -> wr is high for 1 cycle with wr_addr = 3, sel = 0 and d_in = 0xA5; done follows 1 cycle later.
REQ-042 ALU op = 2, destination r1, sources r3 and r3 (instr 0xC5B0) -> rd_addr_a = rd_addr_b = 3, op = 2 and sel = 1 from EXEC; the register file reads back 0x5A.
REQ-043 in_valid held high with 3 back-to-back LOADs -> exactly 3 accepts, 4 cycles apart, with in_ready low for 3 cycles after each accept.
REQ-044 Reset asserted during WRITE -> wr drops immediately, no done pulse occurs, and the next instruction executes normally.
REQ-045 ALU instruction with cout_in = 1 in FLAG -> carry = 1; a following LOAD -> carry stays 1.
REQ-046 With REG_ALU_CTRL_PERF_EN and CNT_W = 4: 17 instructions -> retired = 1 (wrap-around).

Source files
------------

// File: rtl/reg_alu_ctrl_pkg.sv
// Shared definitions for the register-file/ALU controller: state encoding,
// instruction field positions, instruction kinds and the decoded-field bundle.
package reg_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FLAG  = 2'd3
  } state_t;

  // Instruction field bit positions
  localparam int KIND_BIT = 15;
  localparam int OP_HI    = 14;
  localparam int OP_LO    = 13;
  localparam int DST_HI   = 12;
  localparam int DST_LO   = 10;
  localparam int SRCA_HI  = 9;
  localparam int SRCA_LO  = 7;
  localparam int SRCB_HI  = 6;
  localparam int SRCB_LO  = 4;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  localparam logic KIND_LOAD = 1'b0;
  localparam logic KIND_ALU  = 1'b1;

  // Everything the register file / ALU needs from one instruction
  typedef struct packed {
    logic       sel;
    logic [1:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wa;
    logic [7:0] d_in;
  } dec_t;

endpackage

// File: rtl/reg_alu_ctrl_decode.sv
// Combinational instruction decode. LOAD drives the immediate with sel=0;
// ALU drives op/sources with sel=1 and a zero immediate. Fields that do not
// belong to the instruction's kind are forced to 0.
module reg_alu_ctrl_decode
  import reg_alu_ctrl_pkg::*;
(
  input  logic [15:0] i_instr,
  output dec_t        o_dec
);

  // Map instruction fields onto register-file / ALU controls
  always_comb begin
    o_dec    = '0;
    o_dec.wa = i_instr[DST_HI:DST_LO];
    if (i_instr[KIND_BIT] == KIND_ALU) begin
      o_dec.sel = 1'b1;
      o_dec.op  = i_instr[OP_HI:OP_LO];
      o_dec.ra  = i_instr[SRCA_HI:SRCA_LO];
      o_dec.rb  = i_instr[SRCB_HI:SRCB_LO];
    end else begin
      o_dec.d_in = i_instr[IMM_HI:IMM_LO];
    end
  end

endmodule

// File: rtl/reg_alu_ctrl.sv
// Register-file / ALU sequencing controller. Accepts one instruction in IDLE,
// then walks EXEC -> WRITE -> FLAG -> IDLE (one instruction per 4 cycles).
// Optional retired-instruction counter: define REG_ALU_CTRL_PERF_EN.
module reg_alu_ctrl
  import reg_alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  output logic             sel,
  output logic             wr,
  output logic [1:0]       op,
  output logic [2:0]       rd_addr_a,
  output logic [2:0]       rd_addr_b,
  output logic [2:0]       wr_addr,
  output logic [7:0]       d_in,
  input  logic             cout_in,
  output logic             carry,
`ifdef REG_ALU_CTRL_PERF_EN
  output logic [CNT_W-1:0] retired,
`endif
  output logic             done
);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instr;
  logic        r_carry;
  logic        w_accept;
  dec_t        w_dec;

  // Next-state and per-state strobes
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    wr       = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_EXEC;
        end
      end
      ST_EXEC:  w_next = ST_WRITE;
      ST_WRITE: begin
        wr     = 1'b1;
        w_next = ST_FLAG;
      end
      ST_FLAG: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Capture the instruction on the accepting edge; it stays put until the next accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_instr <= '0;
    else if (w_accept) r_instr <= instr;
  end

  // Carry is refreshed only when an ALU instruction leaves FLAG
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_carry <= 1'b0;
    else if (r_state == ST_FLAG && r_instr[KIND_BIT] == KIND_ALU)
      r_carry <= cout_in;
  end

  reg_alu_ctrl_decode u_decode (
    .i_instr (r_instr),
    .o_dec   (w_dec)
  );

  assign sel       = w_dec.sel;
  assign op        = w_dec.op;
  assign rd_addr_a = w_dec.ra;
  assign rd_addr_b = w_dec.rb;
  assign wr_addr   = w_dec.wa;
  assign d_in      = w_dec.d_in;
  assign carry     = r_carry;

`ifdef REG_ALU_CTRL_PERF_EN
  logic [CNT_W-1:0] r_retired;

  // Count retirements; wraps naturally at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_retired <= '0;
    else if (done) r_retired <= r_retired + 1'b1;
  end

  assign retired = r_retired;
`endif

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Self-checking bench for reg_alu_ctrl. A negedge monitor walks a phase model
// of each accepted instruction against a scoreboard of decoded expectations.
module tb_reg_alu_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      instr;
  logic             sel;
  logic             wr;
  logic [1:0]       op;
  logic [2:0]       rd_addr_a;
  logic [2:0]       rd_addr_b;
  logic [2:0]       wr_addr;
  logic [7:0]       d_in;
  logic             cout_in;
  logic             carry;
  logic             done;
`ifdef REG_ALU_CTRL_PERF_EN
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] m_ret = '0;
`endif

  reg_alu_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .sel       (sel),
    .wr        (wr),
    .op        (op),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_addr   (wr_addr),
    .d_in      (d_in),
    .cout_in   (cout_in),
    .carry     (carry),
`ifdef REG_ALU_CTRL_PERF_EN
    .retired   (retired),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       alu;
    logic       sel;
    logic [1:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wa;
    logic [7:0] d;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   m_ph  = 0;   // 3=EXEC 2=WRITE 1=FLAG 0=IDLE
  logic m_carry = 1'b0;
  int   cyc = 0;
  bit   b2b = 1'b0;
  int   acc_n = 0;
  int   last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t exp_of(input logic [15:0] ins);
    exp_t e;
    e.alu = ins[15];
    e.sel = ins[15];
    e.wa  = ins[12:10];
    e.op  = ins[15] ? ins[14:13] : 2'd0;
    e.ra  = ins[15] ? ins[9:7]   : 3'd0;
    e.rb  = ins[15] ? ins[6:4]   : 3'd0;
    e.d   = ins[15] ? 8'h00      : ins[7:0];
    return e;
  endfunction

  // Monitor: sample away from the active edge and step the phase model
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      chk("rst_ready", in_ready, 1);
      chk("rst_wr",    wr,       0);
      chk("rst_done",  done,     0);
      chk("rst_carry", carry,    0);
      chk("rst_dec",   {sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in}, 0);
      sbq.delete();
      m_ph    = 0;
      m_carry = 1'b0;
`ifdef REG_ALU_CTRL_PERF_EN
      chk("rst_retired", retired, 0);
      m_ret = '0;
`endif
    end else begin
      case (m_ph)
        0: begin
          chk("idle_ready", in_ready, 1);
          chk("idle_wr",    wr,       0);
          chk("idle_done",  done,     0);
          chk("idle_carry", carry,    m_carry);
`ifdef REG_ALU_CTRL_PERF_EN
          chk("retired", retired, m_ret);
`endif
          if (in_valid && in_ready) begin
            sbq.push_back(exp_of(instr));
            m_ph = 3;
            if (b2b) begin
              if (acc_n > 0) chk("b2b_gap", cyc - last_acc, 4);
              acc_n++;
              last_acc = cyc;
            end
          end
        end
        3, 2: begin
          if (sbq.size() == 0) chk("sb_empty", sbq.size(), 1);
          else begin
            e = sbq[0];
            chk("busy_ready", in_ready, 0);
            chk("busy_done",  done,     0);
            chk("wr_phase",   wr,       (m_ph == 2) ? 1 : 0);
            chk("sel",        sel,      e.sel);
            chk("wr_addr",    wr_addr,  e.wa);
            chk("d_in",       d_in,     e.d);
            if (e.alu) begin
              chk("op",    op,        e.op);
              chk("rd_a",  rd_addr_a, e.ra);
              chk("rd_b",  rd_addr_b, e.rb);
            end
          end
          m_ph--;
        end
        default: begin
          chk("flag_done",  done,     1);
          chk("flag_wr",    wr,       0);
          chk("flag_ready", in_ready, 0);
          if (sbq.size() == 0) chk("sb_empty", sbq.size(), 1);
          else begin
            e = sbq.pop_front();
            if (e.alu) m_carry = cout_in;
          end
`ifdef REG_ALU_CTRL_PERF_EN
          m_ret = m_ret + 1'b1;
`endif
          m_ph = 0;
        end
      endcase
    end
  end

  // Offer an instruction once the controller is ready; scribble instr while busy
  task automatic send(input logic [15:0] ins, input logic cin, input bit hold);
    int n = 0;
    while (!in_ready && n < 20) begin
      instr = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_to", in_ready, 1);
    else begin
      instr    = ins;
      in_valid = 1'b1;
      cout_in  = cin;
      @(posedge clk); #1;
      if (!hold) begin
        in_valid = 1'b0;
        instr    = 16'($urandom);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((m_ph != 0 || !in_ready) && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_to", (m_ph == 0) ? 1 : 0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    instr    = 16'h0;
    cout_in  = 1'b0;
    #3;
    chk("init_ready", in_ready, 1);
    chk("init_wr",    wr,       0);
    chk("init_done",  done,     0);
    chk("init_carry", carry,    0);
    chk("init_waddr", wr_addr,  0);
    chk("init_din",   d_in,     0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // LOAD r3 <- 0xA5
    send(16'h0CA5, 1'b0, 1'b0);
    drain();

    // ALU op2, r1 <- r3 op r3 (source equals nothing special, dest differs)
    send(16'hC5B0, 1'b0, 1'b0);
    drain();

    // Source equals destination: ALU op1, r2 <- r2 op r5
    send(16'hA950, 1'b0, 1'b0);
    drain();

    // Three back-to-back LOADs with in_valid held high
    b2b   = 1'b1;
    acc_n = 0;
    send(16'h0C11, 1'b0, 1'b1);
    send(16'h1022, 1'b0, 1'b1);
    send(16'h1C33, 1'b0, 1'b0);
    drain();
    b2b = 1'b0;
    chk("b2b_cnt", acc_n, 3);

    // Carry set by ALU, held through a LOAD
    send(16'hF8F0, 1'b1, 1'b0);
    drain();
    chk("carry_set", carry, 1);
    send(16'h047E, 1'b0, 1'b0);
    drain();
    chk("carry_hold", carry, 1);

    // Reset during WRITE aborts the instruction
    send(16'h2C7E, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("pre_wr", wr, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_wr",    wr,       0);
    chk("abort_done",  done,     0);
    chk("abort_ready", in_ready, 1);
    chk("abort_carry", carry,    0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(16'h0CA5, 1'b0, 1'b0);
    drain();

    // 17 random instructions after a fresh reset
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      send(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0);
      drain();
    end
`ifdef REG_ALU_CTRL_PERF_EN
    chk("retired_wrap", retired, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
